clock_monitor: RTL

Synthesizable monitor that measures an incoming clock-like signal (`mon_clk`) against the system `clock`. Reports period and high time in system-clock cycles, flags out-of-tolerance periods and detects a stopped clock. Sits beside the testbench/behavioural clock generator and on-chip derived clocks, checking what they actually produce.

---
 rtl/clock_monitor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/clock_monitor.sv
// clock_monitor: measures period and high time of an asynchronous mon_clk in clock cycles,
// flags out-of-tolerance periods and a stopped clock. Define CLOCK_MONITOR_DUTY_EN for high-time counting.
module clock_monitor #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EXP_PERIOD = 10,
    parameter int unsigned TOL        = 1,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             fault,
    output logic             stopped
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   EXP_EXT     = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W+1)'(TOL);

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   deviation;
    logic             period_bad;

    // Synchroniser and edge history run independently of enable so no edge is lost on re-enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign cnt_sat = &cnt;
    assign cnt_ext = {1'b0, cnt};

    always_comb begin
        deviation = '0;
        if (cnt_ext >= EXP_EXT) begin
            deviation = cnt_ext - EXP_EXT;
        end else begin
            deviation = EXP_EXT - cnt_ext;
        end
    end

    assign period_bad = cnt_sat | (deviation > TOL_EXT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            fault   <= 1'b0;
            stopped <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // A rise coinciding with the timeout count is still a measurement.
                        if (rise) begin
                            period  <= cnt;
                            fault   <= period_bad;
                            valid   <= 1'b1;
                            stopped <= 1'b0;
                            cnt     <= CNT_ONE;
                        end else if (cnt == CNT_TIMEOUT) begin
                            stopped <= 1'b1;
                            state   <= ARM;
                        end else if (!cnt_sat) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef CLOCK_MONITOR_DUTY_EN
    logic [CNT_W-1:0] hcnt;
    logic             lvl;

    assign lvl = s2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcnt      <= '0;
            high_time <= '0;
        end else if (!enable || state == IDLE) begin
            hcnt <= '0;
        end else if (rise) begin
            if (state == MEASURE) begin
                high_time <= hcnt;
            end
            hcnt <= CNT_ONE;
        end else if (state == MEASURE && cnt != CNT_TIMEOUT && lvl && !(&hcnt)) begin
            hcnt <= hcnt + CNT_ONE;
        end
    end
`else
    assign high_time = '0;
`endif

endmodule
